csr_trap_unit: RTL and testbench
================================

// Module: csr_trap_unit
// PURPOSE
// - Parametrised machine-mode CSR file with atomic read-modify-write ops and a trap sequencer.
// - Sits beside the execute stage: it supplies the old CSR value to the writeback mux,
//   captures mepc/mcause on interrupt entry and redirects fetch on trap entry and on mret.
// - Generalises the flat 32-entry CSR array: adds configurable width and depth,
//   RW/RS/RC semantics, illegal-address detection and a sequenced trap FSM.
// PARAMETERS
// - XLEN       32          data width of every CSR and of the PC
// - DEPTH      16          number of implemented CSR entries (>=4, power of 2)
// - ADDR_W     12          width of csr_addr (RISC-V CSR address space)
// - CAUSE_W    4           width of irq_cause
// - RESET_VEC  32'h0000_0100  reset value of mtvec
// PORTS
// - clk            in   1        rising-edge clock
// - rst_n          in   1        asynchronous active-low reset
// - csr_req        in   1        CSR instruction valid this cycle
// - csr_op         in   2        01=RW, 10=RS (set bits), 11=RC (clear bits), 00=read only
// - csr_addr       in   ADDR_W   CSR index
// - csr_wdata      in   XLEN     rs1 / zimm operand
// - csr_rdata      out  XLEN     old CSR value, combinational, same cycle as csr_req
// - csr_illegal    out  1        csr_addr >= DEPTH while csr_req
// - csr_stall      out  1        trap FSM busy; csr_req not accepted
// - pc             in   XLEN     PC of the instruction being interrupted
// - irq_pending    in   1        level interrupt request
// - irq_cause      in   CAUSE_W  interrupt cause code
// - irq_ack        out  1        one-cycle pulse, interrupt accepted
// - mret           in   1        mret retiring this cycle
// - trap_redirect  out  1        one-cycle pulse, fetch must jump to trap_pc
// - trap_pc        out  XLEN     redirect target, valid while trap_redirect
// BEHAVIOUR
// - Fixed map. idx0 = mstatus (bit3 MIE, bit7 MPIE; other bits read 0).
//   idx1 = mtvec. idx2 = mepc (bits[1:0] read 0). idx3 = mcause. idx4..DEPTH-1 = general scratch.
// - Reset: all CSRs 0 except mtvec = RESET_VEC; FSM = IDLE; all outputs 0.
// - Write value: RW -> wdata; RS -> old|wdata; RC -> old&~wdata. Value is committed on the next posedge.
// - No write occurs for:
//   - csr_op=00;
//   - RS/RC with csr_wdata==0;
//   - csr_illegal (csr_rdata=0 in this case);
//   - csr_stall.
// - Read-after-write: the cycle after a write, csr_rdata returns the new value (no bypass is needed).
// - FSM states and transitions:
//   - IDLE -> SAVE: irq_pending & MIE & !mret.
//   - SAVE -> REDIR: in SAVE, irq_ack=1 and the following are written at the posedge:
//     - mepc <= pc;
//     - mcause <= {1'b1, zero-pad, irq_cause};
//     - MPIE <= MIE; MIE <= 0.
//   - REDIR -> IDLE: trap_redirect=1, trap_pc = {mtvec[XLEN-1:2], 2'b00}.
//   - IDLE -> RET: on mret, MIE <= MPIE and MPIE <= 1.
//   - RET -> IDLE: trap_redirect=1, trap_pc = mepc.
// - csr_stall=1 in SAVE, REDIR and RET. csr_rdata remains readable while stalled.
// - Simultaneous events:
//   - mret & irq_pending in IDLE: mret wins; the irq is re-evaluated in IDLE after RET.
//   - csr write & trap entry in the same cycle (IDLE): the CSR write commits first.
//     SAVE in the next cycle then overwrites mepc/mcause/mstatus.
//   - irq_pending deasserted during SAVE: the trap still completes.
// - Reset asserted mid-sequence: FSM -> IDLE and all pulses drop immediately (async).
// - Latency: irq accept -> redirect = 2 cycles; mret -> redirect = 1 cycle.
// CONFIGURATION
// - CSR_MCYCLE_EN defined:
//   - Adds a free-running 64-bit cycle counter that increments every cycle out of reset.
//   - idx DEPTH-2 reads the low XLEN bits; idx DEPTH-1 reads the high bits (XLEN=32).
//   - Writes to these two indices load the corresponding half; the written value is seen the next cycle.
// - CSR_MCYCLE_EN undefined: those indices are ordinary scratch registers.
// TESTING
// - Reset: release rst_n, read idx1 -> 0x0000_0100; read idx0, idx2, idx3 -> 0.
// - RW/RS/RC on idx5:
//   - RW 0xA5A5_0000 -> rdata 0;
//   - RS 0x0000_00FF -> rdata 0xA5A5_0000;
//   - RC 0xA500_0000 -> rdata 0xA5A5_00FF; next read 0x00A5_00FF.
// - Illegal access: csr_addr=0x010 with DEPTH=16 -> csr_illegal=1, rdata=0, no state change.
// - Trap entry:
//   - Setup: mstatus=0x8, mtvec=0x200, pc=0x1234, cause=5.
//   - Response: irq_ack at T+1; trap_redirect at T+2 with trap_pc=0x200.
//   - Final CSRs: mepc=0x1234, mcause=0x8000_0005, mstatus=0x80.
// - mret: from the trap state above, pulse mret -> next cycle redirect to 0x1234; mstatus=0x88.
// - Masked/priority: with MIE=0, irq_pending -> no irq_ack. With mret & irq together -> RET taken first.

Source files
------------

// File: rtl/csr_trap_unit_if.sv
// ---------------------------------------------------------------------------
// csr_trap_unit_if
// Bundle of the CSR access port, the interrupt/mret inputs and the fetch
// redirect outputs that connect the execute stage to csr_trap_unit.
//   master : pipeline side (drives csr_req/op/addr/wdata, pc, irq_*, mret)
//   slave  : csr_trap_unit side (drives csr_rdata, csr_illegal, csr_stall,
//            irq_ack, trap_redirect, trap_pc)
// Parameters must match those of the csr_trap_unit instance.
// ---------------------------------------------------------------------------
interface csr_trap_unit_if #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 12,
  parameter int CAUSE_W = 4
);
  logic                csr_req;
  logic [1:0]          csr_op;
  logic [ADDR_W-1:0]   csr_addr;
  logic [XLEN-1:0]     csr_wdata;
  logic [XLEN-1:0]     csr_rdata;
  logic                csr_illegal;
  logic                csr_stall;
  logic [XLEN-1:0]     pc;
  logic                irq_pending;
  logic [CAUSE_W-1:0]  irq_cause;
  logic                irq_ack;
  logic                mret;
  logic                trap_redirect;
  logic [XLEN-1:0]     trap_pc;

  modport master (
    output csr_req, csr_op, csr_addr, csr_wdata, pc, irq_pending, irq_cause, mret,
    input  csr_rdata, csr_illegal, csr_stall, irq_ack, trap_redirect, trap_pc
  );

  modport slave (
    input  csr_req, csr_op, csr_addr, csr_wdata, pc, irq_pending, irq_cause, mret,
    output csr_rdata, csr_illegal, csr_stall, irq_ack, trap_redirect, trap_pc
  );
endinterface

// File: rtl/csr_trap_unit.sv
// ---------------------------------------------------------------------------
// csr_trap_unit
// Machine-mode CSR file with atomic read-modify-write (RW/RS/RC) and a trap
// sequencer that saves mepc/mcause on interrupt entry and redirects fetch on
// trap entry and on mret.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : csr_trap_unit_if.slave
//           csr_req/op/addr/wdata -> csr_rdata (old value, combinational),
//           csr_illegal, csr_stall; pc/irq_pending/irq_cause -> irq_ack;
//           mret; trap_redirect/trap_pc.
//
// CSR map: 0 mstatus (bit3 MIE, bit7 MPIE), 1 mtvec, 2 mepc (bits[1:0]=0),
//          3 mcause, 4..DEPTH-1 scratch.
//
// Optional feature macro: CSR_MCYCLE_EN
//   Defined: a free-running 64-bit cycle counter replaces scratch entries
//   DEPTH-2 (low half) and DEPTH-1 (high half); writes load that half.
//   Undefined: those entries are ordinary scratch registers.
// ---------------------------------------------------------------------------
module csr_trap_unit #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 16,
  parameter int              ADDR_W    = 12,
  parameter int              CAUSE_W   = 4,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0100
) (
  input logic              clk,
  input logic              rst_n,
  csr_trap_unit_if.slave   bus
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic [IDX_W-1:0] IDX_MSTATUS = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_MTVEC   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_MEPC    = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_MCAUSE  = IDX_W'(3);

  // Only MIE (bit 3) and MPIE (bit 7) of mstatus are implemented.
  localparam logic [XLEN-1:0] MSTATUS_MASK = {{(XLEN-8){1'b0}}, 8'h88};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SAVE  = 2'b01,
    ST_REDIR = 2'b10,
    ST_RET   = 2'b11
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [XLEN-1:0] csr_r     [DEPTH];
  logic [XLEN-1:0] csr_nxt_s [DEPTH];

  logic [IDX_W-1:0] idx_s;
  logic             illegal_s;
  logic             wr_en_s;
  logic [XLEN-1:0]  rd_val_s;
  logic [XLEN-1:0]  wr_val_s;
  logic             save_s;
  logic             do_mret_s;
  logic             stall_s;
  logic             irq_ack_s;
  logic             redirect_s;
  logic [XLEN-1:0]  trap_pc_s;

`ifdef CSR_MCYCLE_EN
  localparam logic [IDX_W-1:0] IDX_CYC_LO = IDX_W'(DEPTH - 2);
  localparam logic [IDX_W-1:0] IDX_CYC_HI = IDX_W'(DEPTH - 1);
  logic [63:0] mcycle_r;
`endif

  // New value of a read-modify-write op given the old value and the operand.
  function automatic logic [XLEN-1:0] rmw_value(input logic [1:0]      op,
                                                input logic [XLEN-1:0] old_val,
                                                input logic [XLEN-1:0] operand);
    case (op)
      OP_RW:   rmw_value = operand;
      OP_RS:   rmw_value = old_val | operand;
      OP_RC:   rmw_value = old_val & ~operand;
      default: rmw_value = old_val;
    endcase
  endfunction

  // Force hard-wired-zero bits of the fixed-layout CSRs before storing.
  function automatic logic [XLEN-1:0] legalize(input logic [IDX_W-1:0] idx,
                                               input logic [XLEN-1:0]  val);
    case (idx)
      IDX_MSTATUS: legalize = val & MSTATUS_MASK;
      IDX_MEPC:    legalize = {val[XLEN-1:2], 2'b00};
      default:     legalize = val;
    endcase
  endfunction

  assign idx_s     = bus.csr_addr[IDX_W-1:0];
  assign illegal_s = bus.csr_req && (bus.csr_addr >= ADDR_W'(DEPTH));

  // Old-value read mux, with the cycle counter overlaid when enabled.
  always_comb begin
    rd_val_s = csr_r[idx_s];
`ifdef CSR_MCYCLE_EN
    if (idx_s == IDX_CYC_LO) begin
      rd_val_s = XLEN'(mcycle_r[31:0]);
    end else if (idx_s == IDX_CYC_HI) begin
      rd_val_s = XLEN'(mcycle_r[63:32]);
    end else begin
      rd_val_s = csr_r[idx_s];
    end
`endif
  end

  // Write qualification: set/clear with a zero operand is a pure read.
  always_comb begin
    wr_val_s = rmw_value(bus.csr_op, rd_val_s, bus.csr_wdata);
    wr_en_s  = 1'b0;
    if (bus.csr_req && !illegal_s && !stall_s) begin
      case (bus.csr_op)
        OP_RW:   wr_en_s = 1'b1;
        OP_RS,
        OP_RC:   wr_en_s = (bus.csr_wdata != {XLEN{1'b0}});
        OP_RD:   wr_en_s = 1'b0;
        default: wr_en_s = 1'b0;
      endcase
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Trap sequencer next-state and decoded outputs.
  always_comb begin
    state_nxt_s = state_r;
    save_s      = 1'b0;
    do_mret_s   = 1'b0;
    stall_s     = 1'b0;
    irq_ack_s   = 1'b0;
    redirect_s  = 1'b0;
    trap_pc_s   = {XLEN{1'b0}};
    case (state_r)
      ST_IDLE: begin
        // mret has priority; a pending irq is re-evaluated after RET.
        if (bus.mret) begin
          do_mret_s   = 1'b1;
          state_nxt_s = ST_RET;
        end else if (bus.irq_pending && csr_r[IDX_MSTATUS][3]) begin
          state_nxt_s = ST_SAVE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SAVE: begin
        save_s      = 1'b1;
        irq_ack_s   = 1'b1;
        stall_s     = 1'b1;
        state_nxt_s = ST_REDIR;
      end
      ST_REDIR: begin
        stall_s     = 1'b1;
        redirect_s  = 1'b1;
        trap_pc_s   = {csr_r[IDX_MTVEC][XLEN-1:2], 2'b00};
        state_nxt_s = ST_IDLE;
      end
      ST_RET: begin
        stall_s     = 1'b1;
        redirect_s  = 1'b1;
        trap_pc_s   = csr_r[IDX_MEPC];
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // CSR next values: instruction write first, then trap/mret side effects.
  always_comb begin
    csr_nxt_s = csr_r;
    if (wr_en_s) begin
      csr_nxt_s[idx_s] = legalize(idx_s, wr_val_s);
    end else begin
      csr_nxt_s[idx_s] = csr_r[idx_s];
    end
    if (save_s) begin
      csr_nxt_s[IDX_MEPC]       = legalize(IDX_MEPC, bus.pc);
      csr_nxt_s[IDX_MCAUSE]     = {1'b1, {(XLEN-1-CAUSE_W){1'b0}}, bus.irq_cause};
      csr_nxt_s[IDX_MSTATUS][7] = csr_r[IDX_MSTATUS][3];
      csr_nxt_s[IDX_MSTATUS][3] = 1'b0;
    end else if (do_mret_s) begin
      csr_nxt_s[IDX_MSTATUS][3] = csr_r[IDX_MSTATUS][7];
      csr_nxt_s[IDX_MSTATUS][7] = 1'b1;
    end else begin
      csr_nxt_s[IDX_MSTATUS] = csr_nxt_s[IDX_MSTATUS];
    end
  end

  // CSR storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        csr_r[i] <= (i == 1) ? RESET_VEC : {XLEN{1'b0}};
      end
    end else begin
      csr_r <= csr_nxt_s;
    end
  end

  // Trap sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

`ifdef CSR_MCYCLE_EN
  // Free-running cycle counter; a CSR write loads one half instead of counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_r <= 64'd0;
    end else if (wr_en_s && (idx_s == IDX_CYC_LO)) begin
      mcycle_r[31:0] <= wr_val_s[31:0];
    end else if (wr_en_s && (idx_s == IDX_CYC_HI)) begin
      mcycle_r[63:32] <= wr_val_s[31:0];
    end else begin
      mcycle_r <= mcycle_r + 64'd1;
    end
  end
`endif

  assign bus.csr_rdata     = (bus.csr_req && !illegal_s) ? rd_val_s : {XLEN{1'b0}};
  assign bus.csr_illegal   = illegal_s;
  assign bus.csr_stall     = stall_s;
  assign bus.irq_ack       = irq_ack_s;
  assign bus.trap_redirect = redirect_s;
  assign bus.trap_pc       = trap_pc_s;

endmodule

// File: tb/tb_csr_trap_unit.sv
// ---------------------------------------------------------------------------
// tb_csr_trap_unit
// Directed self-checking bench for csr_trap_unit (default configuration).
// Inputs change 1 time unit after each rising edge; outputs are checked
// 3 time units later, well away from either clock edge.
// ---------------------------------------------------------------------------
module tb_csr_trap_unit;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  csr_trap_unit_if #(.XLEN(32), .ADDR_W(12), .CAUSE_W(4)) bus ();

  csr_trap_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10-unit clock period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic clear_inputs();
    bus.csr_req     = 1'b0;
    bus.csr_op      = 2'b00;
    bus.csr_addr    = 12'h000;
    bus.csr_wdata   = 32'h0000_0000;
    bus.pc          = 32'h0000_0000;
    bus.irq_pending = 1'b0;
    bus.irq_cause   = 4'h0;
    bus.mret        = 1'b0;
  endtask

  // One CSR instruction: check the old value returned, then let it commit.
  task automatic csr_op(input logic [1:0] op, input logic [11:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_old,
                        input string tag);
    bus.csr_req   = 1'b1;
    bus.csr_op    = op;
    bus.csr_addr  = addr;
    bus.csr_wdata = wdata;
    settle();
    chk(tag, bus.csr_rdata, exp_old);
    next_cycle();
    bus.csr_req   = 1'b0;
    bus.csr_op    = 2'b00;
    bus.csr_wdata = 32'h0000_0000;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    clear_inputs();

    // Reset state
    settle();
    chk("rst_irq_ack",  {31'd0, bus.irq_ack},       32'd0);
    chk("rst_redirect", {31'd0, bus.trap_redirect}, 32'd0);
    chk("rst_stall",    {31'd0, bus.csr_stall},     32'd0);
    chk("rst_rdata",    bus.csr_rdata,              32'd0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    csr_op(2'b00, 12'h001, 32'h0, 32'h0000_0100, "rst_mtvec");
    csr_op(2'b00, 12'h000, 32'h0, 32'h0000_0000, "rst_mstatus");
    csr_op(2'b00, 12'h002, 32'h0, 32'h0000_0000, "rst_mepc");
    csr_op(2'b00, 12'h003, 32'h0, 32'h0000_0000, "rst_mcause");

    // RW / RS / RC on scratch idx5
    csr_op(2'b01, 12'h005, 32'hA5A5_0000, 32'h0000_0000, "rw_idx5");
    csr_op(2'b10, 12'h005, 32'h0000_00FF, 32'hA5A5_0000, "rs_idx5");
    csr_op(2'b11, 12'h005, 32'hA500_0000, 32'hA5A5_00FF, "rc_idx5");
    csr_op(2'b00, 12'h005, 32'h0,         32'h00A5_00FF, "rd_idx5");
    csr_op(2'b11, 12'h005, 32'h0,         32'h00A5_00FF, "rc_zero_idx5");
    csr_op(2'b00, 12'h005, 32'h0,         32'h00A5_00FF, "rd_idx5_after_rc0");

    // Illegal address: index would alias to mstatus if not rejected
    bus.csr_req   = 1'b1;
    bus.csr_op    = 2'b01;
    bus.csr_addr  = 12'h010;
    bus.csr_wdata = 32'hFFFF_FFFF;
    settle();
    chk("illegal_flag",  {31'd0, bus.csr_illegal}, 32'd1);
    chk("illegal_rdata", bus.csr_rdata,            32'd0);
    next_cycle();
    clear_inputs();
    csr_op(2'b00, 12'h000, 32'h0, 32'h0000_0000, "illegal_no_write");
    bus.csr_req  = 1'b1;
    bus.csr_addr = 12'h00F;
    settle();
    chk("legal_top_idx", {31'd0, bus.csr_illegal}, 32'd0);
    next_cycle();
    clear_inputs();

`ifndef CSR_MCYCLE_EN
    // Top entries hold their value as scratch in the default build
    csr_op(2'b01, 12'h00F, 32'h0000_1357, 32'h0, "scratch15_wr");
    next_cycle();
    next_cycle();
    csr_op(2'b00, 12'h00F, 32'h0, 32'h0000_1357, "scratch15_hold");
`endif

    // Masked interrupt: MIE=0
    bus.irq_pending = 1'b1;
    bus.irq_cause   = 4'h5;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("masked_no_ack", {31'd0, bus.irq_ack}, 32'd0);
      next_cycle();
    end
    bus.irq_pending = 1'b0;

    // Setup: mstatus masking, mtvec, MIE=1
    csr_op(2'b01, 12'h000, 32'hFFFF_FFFF, 32'h0000_0000, "mstatus_wr_all");
    csr_op(2'b01, 12'h000, 32'h0000_0008, 32'h0000_0088, "mstatus_masked");
    csr_op(2'b01, 12'h001, 32'h0000_0200, 32'h0000_0100, "mtvec_wr");

    // Trap entry
    bus.irq_pending = 1'b1;
    bus.irq_cause   = 4'h5;
    bus.pc          = 32'h0000_1234;
    settle();
    chk("trap_t0_ack", {31'd0, bus.irq_ack}, 32'd0);
    next_cycle();
    bus.irq_pending = 1'b0;
    settle();
    chk("trap_t1_ack",      {31'd0, bus.irq_ack},       32'd1);
    chk("trap_t1_stall",    {31'd0, bus.csr_stall},     32'd1);
    chk("trap_t1_redirect", {31'd0, bus.trap_redirect}, 32'd0);
    next_cycle();
    bus.csr_req   = 1'b1;
    bus.csr_op    = 2'b01;
    bus.csr_addr  = 12'h006;
    bus.csr_wdata = 32'h0000_0055;
    settle();
    chk("trap_t2_redirect", {31'd0, bus.trap_redirect}, 32'd1);
    chk("trap_t2_pc",       bus.trap_pc,                32'h0000_0200);
    chk("trap_t2_ack",      {31'd0, bus.irq_ack},       32'd0);
    chk("stall_rdata",      bus.csr_rdata,              32'h0000_0000);
    next_cycle();
    clear_inputs();
    settle();
    chk("trap_t3_redirect", {31'd0, bus.trap_redirect}, 32'd0);
    chk("trap_t3_stall",    {31'd0, bus.csr_stall},     32'd0);
    next_cycle();
    csr_op(2'b00, 12'h002, 32'h0, 32'h0000_1234, "trap_mepc");
    csr_op(2'b00, 12'h003, 32'h0, 32'h8000_0005, "trap_mcause");
    csr_op(2'b00, 12'h000, 32'h0, 32'h0000_0080, "trap_mstatus");
    csr_op(2'b00, 12'h006, 32'h0, 32'h0000_0000, "stall_no_write");

    // mret
    bus.mret = 1'b1;
    settle();
    chk("mret_t0_redirect", {31'd0, bus.trap_redirect}, 32'd0);
    next_cycle();
    bus.mret = 1'b0;
    settle();
    chk("mret_t1_redirect", {31'd0, bus.trap_redirect}, 32'd1);
    chk("mret_t1_pc",       bus.trap_pc,                32'h0000_1234);
    chk("mret_t1_stall",    {31'd0, bus.csr_stall},     32'd1);
    next_cycle();
    csr_op(2'b00, 12'h000, 32'h0, 32'h0000_0088, "mret_mstatus");

    // mret and irq together: RET first, then the irq is taken
    bus.mret        = 1'b1;
    bus.irq_pending = 1'b1;
    bus.irq_cause   = 4'h3;
    bus.pc          = 32'h0000_4003;
    settle();
    chk("prio_t0_ack", {31'd0, bus.irq_ack}, 32'd0);
    next_cycle();
    bus.mret = 1'b0;
    settle();
    chk("prio_ret_redirect", {31'd0, bus.trap_redirect}, 32'd1);
    chk("prio_ret_pc",       bus.trap_pc,                32'h0000_1234);
    chk("prio_ret_ack",      {31'd0, bus.irq_ack},       32'd0);
    next_cycle();
    settle();
    chk("prio_idle_ack", {31'd0, bus.irq_ack}, 32'd0);
    next_cycle();
    bus.irq_pending = 1'b0;
    settle();
    chk("prio_save_ack", {31'd0, bus.irq_ack}, 32'd1);
    next_cycle();
    settle();
    chk("prio_redir_pc", bus.trap_pc, 32'h0000_0200);
    next_cycle();
    clear_inputs();
    csr_op(2'b00, 12'h002, 32'h0, 32'h0000_4000, "prio_mepc_aligned");
    csr_op(2'b00, 12'h003, 32'h0, 32'h8000_0003, "prio_mcause");
    csr_op(2'b00, 12'h000, 32'h0, 32'h0000_0080, "prio_mstatus");

    // Reset asserted mid-sequence
    csr_op(2'b01, 12'h000, 32'h0000_0008, 32'h0000_0080, "rst_seq_mie");
    bus.irq_pending = 1'b1;
    bus.irq_cause   = 4'h1;
    next_cycle();
    settle();
    chk("mid_save_ack", {31'd0, bus.irq_ack}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ack",   {31'd0, bus.irq_ack},   32'd0);
    chk("mid_rst_stall", {31'd0, bus.csr_stall}, 32'd0);
    clear_inputs();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    settle();
    chk("post_rst_redirect", {31'd0, bus.trap_redirect}, 32'd0);
    next_cycle();
    csr_op(2'b00, 12'h001, 32'h0, 32'h0000_0100, "post_rst_mtvec");
    csr_op(2'b00, 12'h000, 32'h0, 32'h0000_0000, "post_rst_mstatus");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
